can_rx_sequencer: RTL and testbench



---
 rtl/can_pkg.sv | 26 ++
 rtl/flex_counter.sv | 23 ++
 rtl/can_rx_sequencer.sv | 159 +++++++++++++++
 tb/tb_can_rx_sequencer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/can_pkg.sv
// Shared types and field lengths for the CAN 2.0A receive path.
package can_pkg;

    typedef enum logic [3:0] {
        IDLE, ID, RTR, IDE, R0, DLC, DATA, CRC,
        CRC_DEL, ACK_SLOT, ACK_DEL, EOF, DONE, ERR
    } rx_state_t;

    localparam int ID_BITS  = 11;
    localparam int DLC_BITS = 4;
    localparam int CRC_BITS = 15;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_STUFF = 2'd1,
        ERR_FORM  = 2'd2,
        ERR_CRC   = 2'd3
    } err_code_t;

    // DLC values above the buffer depth still carry only max_dlc bytes.
    function automatic logic [3:0] clamp_dlc(input logic [3:0] dlc, input int max_dlc);
        if (int'(dlc) > max_dlc) return 4'(max_dlc);
        return dlc;
    endfunction

endpackage

// File: rtl/flex_counter.sv
// Enabled up-counter that wraps to zero after reaching a loadable rollover value.
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out
);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            count_out <= '0;
        end else if (clear) begin
            count_out <= '0;
        end else if (count_enable) begin
            count_out <= (count_out == rollover_val) ? '0 : count_out + NUM_CNT_BITS'(1);
        end
    end

endmodule

// File: rtl/can_rx_sequencer.sv
// Frame-level CAN 2.0A receive controller: walks the destuffed bit stream field by
// field, captures ID/DLC/data, gates the CRC comparator, drives ACK and reports status.
module can_rx_sequencer
    import can_pkg::*;
#(
    parameter int MAX_DLC  = 8,
    parameter int EOF_BITS = 7
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        bit_valid,
    input  logic        rxd,
    input  logic        stuff_err,
    input  logic        crc_ok,
    input  logic        listen_only,
    output logic        crc_check_en,
    output logic        ack_drive,
    output logic [10:0] rx_id,
    output logic        rx_rtr,
    output logic [3:0]  rx_dlc,
    output logic [7:0]  rx_byte,
    output logic        byte_valid,
    output logic        frame_done,
    output logic        frame_ok,
    output logic [1:0]  err_code
);

    rx_state_t  state, state_nxt;
    err_code_t  err_now;
    logic       stuff_active, form_bad, error_hit;
    logic [3:0] cnt, cnt_roll;
    logic       cnt_en, cnt_clear, field_last;
    logic [3:0] byte_cnt, byte_cnt_nxt;
    logic [6:0] data_cnt, data_last_idx;
    logic [6:0] data_shift;

    assign byte_cnt      = clamp_dlc(rx_dlc, MAX_DLC);
    assign byte_cnt_nxt  = clamp_dlc({rx_dlc[2:0], rxd}, MAX_DLC);
    assign data_last_idx = {byte_cnt, 3'b000} - 7'd1;
    assign crc_check_en  = (state == CRC) || (state == CRC_DEL);
    assign field_last    = (cnt == cnt_roll);

    // Stuffing is only live from ID through CRC; errors resolve stuff > form > crc.
    always_comb begin
        stuff_active = state inside {ID, RTR, IDE, R0, DLC, DATA, CRC};
        form_bad     = ((state == IDE) && rxd) ||
                       ((state inside {CRC_DEL, ACK_DEL, EOF}) && !rxd);
        if (stuff_active && stuff_err)         err_now = ERR_STUFF;
        else if (form_bad)                     err_now = ERR_FORM;
        else if ((state == CRC_DEL) && !crc_ok) err_now = ERR_CRC;
        else                                   err_now = ERR_NONE;
        error_hit = bit_valid && (err_now != ERR_NONE);
    end

    always_comb begin
        case (state)
            ID:       cnt_roll = 4'(ID_BITS - 1);
            DLC:      cnt_roll = 4'(DLC_BITS - 1);
            CRC:      cnt_roll = 4'(CRC_BITS - 1);
            EOF, ERR: cnt_roll = 4'(EOF_BITS - 1);
            default:  cnt_roll = 4'd0;
        endcase
        cnt_en    = bit_valid && !error_hit &&
                    ((state inside {ID, DLC, CRC, EOF}) || ((state == ERR) && rxd));
        cnt_clear = error_hit || (bit_valid && (state == ERR) && !rxd);
    end

    flex_counter #(.NUM_CNT_BITS(4)) u_field_cnt (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (cnt_clear),
        .count_enable (cnt_en),
        .rollover_val (cnt_roll),
        .count_out    (cnt)
    );

    always_comb begin
        state_nxt = state;
        if (state == DONE) begin
            state_nxt = IDLE;
        end else if (error_hit) begin
            state_nxt = ERR;
        end else if (bit_valid) begin
            case (state)
                IDLE:     if (!rxd) state_nxt = ID;
                ID:       if (field_last) state_nxt = RTR;
                RTR:      state_nxt = IDE;
                IDE:      state_nxt = R0;
                R0:       state_nxt = DLC;
                DLC:      if (field_last)
                              state_nxt = (!rx_rtr && (byte_cnt_nxt != 4'd0)) ? DATA : CRC;
                DATA:     if (data_cnt == data_last_idx) state_nxt = CRC;
                CRC:      if (field_last) state_nxt = CRC_DEL;
                CRC_DEL:  state_nxt = ACK_SLOT;
                ACK_SLOT: state_nxt = ACK_DEL;
                ACK_DEL:  state_nxt = EOF;
                EOF:      if (field_last) state_nxt = DONE;
                ERR:      if (rxd && field_last) state_nxt = IDLE;
                default:  state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state      <= IDLE;
            ack_drive  <= 1'b0;
            rx_id      <= '0;
            rx_rtr     <= 1'b0;
            rx_dlc     <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            err_code   <= ERR_NONE;
            data_cnt   <= '0;
            data_shift <= '0;
        end else begin
            state      <= state_nxt;
            byte_valid <= 1'b0;
            frame_done <= 1'b0;
            if (state == DONE) begin
                frame_done <= 1'b1;
                frame_ok   <= 1'b1;
                err_code   <= ERR_NONE;
            end else if (error_hit) begin
                frame_done <= 1'b1;
                frame_ok   <= 1'b0;
                err_code   <= err_now;
                ack_drive  <= 1'b0;
                data_cnt   <= '0;
            end else if (bit_valid) begin
                case (state)
                    IDLE: if (!rxd) begin
                        rx_id    <= '0;
                        rx_rtr   <= 1'b0;
                        rx_dlc   <= '0;
                        data_cnt <= '0;
                    end
                    ID:  rx_id  <= {rx_id[9:0], rxd};
                    RTR: rx_rtr <= rxd;
                    DLC: rx_dlc <= {rx_dlc[2:0], rxd};
                    DATA: begin
                        data_shift <= {data_shift[5:0], rxd};
                        if (data_cnt[2:0] == 3'd7) begin
                            rx_byte    <= {data_shift, rxd};
                            byte_valid <= 1'b1;
                        end
                        data_cnt <= (data_cnt == data_last_idx) ? 7'd0 : data_cnt + 7'd1;
                    end
                    CRC_DEL:  ack_drive <= crc_ok && !listen_only;
                    ACK_SLOT: ack_drive <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_can_rx_sequencer.sv
// Self-checking bench for can_rx_sequencer: builds bit-level frames, queues expected
// bytes and frame results, and compares them as the receiver reports them.
module tb_can_rx_sequencer;
    import can_pkg::*;

    logic        clk = 1'b0;
    logic        n_rst, bit_valid, rxd, stuff_err, crc_ok, listen_only;
    logic        crc_check_en, ack_drive, rx_rtr, byte_valid, frame_done, frame_ok;
    logic [10:0] rx_id;
    logic [3:0]  rx_dlc;
    logic [7:0]  rx_byte;
    logic [1:0]  err_code;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_q[$];
    logic [2:0] done_q[$];

    can_rx_sequencer #(.MAX_DLC(8), .EOF_BITS(7)) dut (
        .clk(clk), .n_rst(n_rst), .bit_valid(bit_valid), .rxd(rxd),
        .stuff_err(stuff_err), .crc_ok(crc_ok), .listen_only(listen_only),
        .crc_check_en(crc_check_en), .ack_drive(ack_drive), .rx_id(rx_id),
        .rx_rtr(rx_rtr), .rx_dlc(rx_dlc), .rx_byte(rx_byte), .byte_valid(byte_valid),
        .frame_done(frame_done), .frame_ok(frame_ok), .err_code(err_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Scoreboard: pop expectations as the receiver reports bytes and frame results.
    logic [7:0] mon_b;
    logic [2:0] mon_d;
    always @(negedge clk) begin
        if (n_rst) begin
            if (byte_valid) begin
                if (exp_q.size() == 0) check("byte_unexpected", 32'd1, 32'd0);
                else begin
                    mon_b = exp_q.pop_front();
                    check("rx_byte", {24'd0, rx_byte}, {24'd0, mon_b});
                end
            end
            if (frame_done) begin
                if (done_q.size() == 0) check("frame_done_unexpected", 32'd1, 32'd0);
                else begin
                    mon_d = done_q.pop_front();
                    check("frame_ok", {31'd0, frame_ok}, {31'd0, mon_d[2]});
                    check("err_code", {30'd0, err_code}, {30'd0, mon_d[1:0]});
                end
            end
        end
    end

    task automatic send_bit(input logic b, input logic se);
        bit_valid = 1'b1;
        rxd       = b;
        stuff_err = se;
        @(negedge clk);
        bit_valid = 1'b0;
        stuff_err = 1'b0;
        rxd       = 1'b1;
    endtask

    task automatic send_run(input logic b, input int n);
        for (int i = 0; i < n; i++) send_bit(b, 1'b0);
    endtask

    function automatic int crc_del_idx(input logic rtr, input logic [3:0] dlc);
        int nb;
        nb = (dlc > 4'd8) ? 8 : int'(dlc);
        return 19 + (rtr ? 0 : nb * 8) + 15;
    endfunction

    // err_type: 0 = error arises from the stream itself, 1 = stuff_err, 2 = force bit dominant
    task automatic send_frame(input logic [10:0] id, input logic rtr, input logic [3:0] dlc,
                              input logic [63:0] data, input logic crc_ok_v, input logic listen,
                              input int gap, input int err_idx, input int err_type,
                              input logic [1:0] exp_code, input int abort_idx);
        logic q[$];
        int   nb, crc_start, crc_del, k;
        logic err_here, exp_en, exp_ack;
        nb = (dlc > 4'd8) ? 8 : int'(dlc);
        q.push_back(1'b0);
        for (int i = 10; i >= 0; i--) q.push_back(id[i]);
        q.push_back(rtr); q.push_back(1'b0); q.push_back(1'b0);
        for (int i = 3; i >= 0; i--) q.push_back(dlc[i]);
        if (!rtr) for (int i = 0; i < nb * 8; i++) q.push_back(data[63 - i]);
        crc_start = q.size();
        for (int i = 0; i < 15; i++) q.push_back(1'($urandom_range(0, 1)));
        crc_del = q.size();
        for (int i = 0; i < 10; i++) q.push_back(1'b1);
        if (err_type == 2) q[err_idx] = 1'b0;
        crc_ok      = crc_ok_v;
        listen_only = listen;
        if (err_idx < 0 && abort_idx < 0) done_q.push_back({1'b1, 2'd0});
        for (int i = 0; i < q.size(); i++) begin
            if (i == abort_idx) return;
            err_here = (i == err_idx);
            if (!rtr && i >= 19 && i < crc_start && ((i - 19) % 8) == 7 && !err_here) begin
                k = (i - 19) / 8;
                exp_q.push_back(data[63 - 8 * k -: 8]);
            end
            if (err_here) done_q.push_back({1'b0, exp_code});
            send_bit(q[i], err_here && (err_type == 1));
            exp_en  = !err_here && (i >= crc_start - 1) && (i < crc_del);
            exp_ack = !err_here && (i == crc_del) && crc_ok_v && !listen;
            check("crc_check_en", {31'd0, crc_check_en}, {31'd0, exp_en});
            check("ack_drive", {31'd0, ack_drive}, {31'd0, exp_ack});
            if (err_here) return;
            repeat (gap) @(negedge clk);
        end
        check("rx_id", {21'd0, rx_id}, {21'd0, id});
        check("rx_rtr", {31'd0, rx_rtr}, {31'd0, rtr});
        check("rx_dlc", {28'd0, rx_dlc}, {28'd0, dlc});
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {1'b0, crc_check_en, ack_drive, rx_id, rx_rtr, rx_dlc, rx_byte,
                    byte_valid, frame_done, frame_ok, err_code}, 32'd0);
        check({tag, "_state"}, 32'(dut.state), 32'(IDLE));
    endtask

    initial begin
        n_rst = 1'b0; bit_valid = 1'b0; rxd = 1'b1; stuff_err = 1'b0;
        crc_ok = 1'b1; listen_only = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        n_rst = 1'b1;
        send_run(1'b1, 3);

        // Basic data frame, bits back-to-back.
        send_frame(11'h123, 1'b0, 4'd2, 64'hA53C_0000_0000_0000, 1'b1, 1'b0, 0, -1, 0, 2'd0, -1);
        send_run(1'b1, 3);

        // CRC mismatch reported on the delimiter bit.
        send_frame(11'h123, 1'b0, 4'd2, 64'hA53C_0000_0000_0000, 1'b0, 1'b0, 0,
                   crc_del_idx(1'b0, 4'd2), 0, 2'd3, -1);
        send_run(1'b1, 7);

        // Dominant CRC delimiter beats the concurrent crc failure, then ERR recovery.
        send_frame(11'h123, 1'b0, 4'd2, 64'hA53C_0000_0000_0000, 1'b0, 1'b0, 0,
                   crc_del_idx(1'b0, 4'd2), 2, 2'd2, -1);
        send_run(1'b1, 6);
        send_run(1'b0, 1);
        send_run(1'b1, 6);
        check("err_wait_state", 32'(dut.state), 32'(ERR));
        send_run(1'b1, 1);
        check("err_exit_state", 32'(dut.state), 32'(IDLE));
        send_run(1'b1, 2);

        // Remote frame: no data bytes despite DLC=5.
        send_frame(11'h7FF, 1'b1, 4'd5, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 0, -1, 0, 2'd0, -1);
        send_run(1'b1, 3);

        // Stuff error on 3rd data bit, then a later crc failure is still reported as crc.
        send_frame(11'h055, 1'b0, 4'd2, 64'h1234_0000_0000_0000, 1'b1, 1'b0, 0, 21, 1, 2'd1, -1);
        send_run(1'b1, 7);
        send_frame(11'h2AA, 1'b0, 4'd1, 64'h8100_0000_0000_0000, 1'b0, 1'b0, 0,
                   crc_del_idx(1'b0, 4'd1), 0, 2'd3, -1);
        send_run(1'b1, 7);

        // Reset mid-DATA with spaced bits, then a clean frame.
        send_frame(11'h321, 1'b0, 4'd3, 64'hDEAD_BE00_0000_0000, 1'b1, 1'b0, 3, -1, 0, 2'd0, 22);
        n_rst = 1'b0;
        @(negedge clk);
        check_all_zero("midframe_reset");
        n_rst = 1'b1;
        send_run(1'b1, 2);
        send_frame(11'h321, 1'b0, 4'd3, 64'hDEAD_BE00_0000_0000, 1'b1, 1'b0, 3, -1, 0, 2'd0, -1);
        send_run(1'b1, 3);

        // DLC above MAX_DLC clamps to 8 bytes; listen-only suppresses ACK; zero-length data.
        send_frame(11'h0F0, 1'b0, 4'd12, 64'h0102_0304_0506_0708, 1'b1, 1'b0, 0, -1, 0, 2'd0, -1);
        send_run(1'b1, 3);
        send_frame(11'h000, 1'b0, 4'd1, 64'h7E00_0000_0000_0000, 1'b1, 1'b1, 1, -1, 0, 2'd0, -1);
        send_run(1'b1, 3);
        send_frame(11'h400, 1'b0, 4'd0, 64'h0, 1'b1, 1'b0, 0, -1, 0, 2'd0, -1);
        send_run(1'b1, 3);

        for (int f = 0; f < 4; f++) begin
            send_frame(11'($urandom_range(0, 2047)), 1'($urandom_range(0, 1)),
                       4'($urandom_range(0, 15)), {$urandom, $urandom}, 1'b1, 1'b0,
                       $urandom_range(0, 2), -1, 0, 2'd0, -1);
            send_run(1'b1, 3);
        end

        repeat (5) @(negedge clk);
        check("bytes_left", exp_q.size(), 32'd0);
        check("frames_left", done_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
